// File: rtl/cpu_state_regs.sv
// Architectural state of the 4-bit CPU: A, B, OUT, PC and carry flag, plus PC sequencing.
// Optional halt-on-jump-to-self is enabled by defining CPU_STATE_REGS_HALT_EN.
module cpu_state_regs #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [1:0]       dst,
    input  logic             jnc,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] pc,
    output logic             c_flag,
    output logic             halted
);

    localparam logic [1:0] DST_A   = 2'd0;
    localparam logic [1:0] DST_B   = 2'd1;
    localparam logic [1:0] DST_OUT = 2'd2;
    localparam logic [1:0] DST_PC  = 2'd3;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             c_q, c_d;
    logic             step;
    logic             taken;

`ifdef CPU_STATE_REGS_HALT_EN
    logic halt_q, halt_d;

    assign step   = en & ~halt_q;
    assign halted = halt_q;
`else
    assign step   = en;
    assign halted = 1'b0;
`endif

    // A conditional write looks at the carry latched before this edge.
    assign taken = wr & (~jnc | ~c_q);

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        pc_d  = pc_q;
        c_d   = c_q;
`ifdef CPU_STATE_REGS_HALT_EN
        halt_d = halt_q;
`endif
        if (step) begin
            pc_d = pc_q + WIDTH'(1);
            if (wr) begin
                c_d = alu_carry;
            end
            if (taken) begin
                case (dst)
                    DST_A:   a_d   = alu_out;
                    DST_B:   b_d   = alu_out;
                    DST_OUT: out_d = alu_out;
                    DST_PC: begin
                        pc_d = alu_out;
`ifdef CPU_STATE_REGS_HALT_EN
                        if (alu_out == pc_q) begin
                            halt_d = 1'b1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
            pc_q  <= '0;
            c_q   <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
            pc_q  <= pc_d;
            c_q   <= c_d;
        end
    end

`ifdef CPU_STATE_REGS_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

    assign reg_a    = a_q;
    assign reg_b    = b_q;
    assign out_port = out_q;
    assign pc       = pc_q;
    assign c_flag   = c_q;

endmodule

// File: tb/tb_cpu_state_regs.sv
// Bench for cpu_state_regs: vector table applied through an expected-value queue,
// plus hand sequences for reset and halt corners. Honours CPU_STATE_REGS_HALT_EN.
module tb_cpu_state_regs;

  localparam int W = 4;
`ifdef CPU_STATE_REGS_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         wr;
  logic [1:0]   dst;
  logic         jnc;
  logic [W-1:0] alu_out;
  logic         alu_carry;
  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  logic [W-1:0] out_port;
  logic [W-1:0] pc;
  logic         c_flag;
  logic         halted;

  cpu_state_regs #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wr        (wr),
    .dst       (dst),
    .jnc       (jnc),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .out_port  (out_port),
    .pc        (pc),
    .c_flag    (c_flag),
    .halted    (halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {reg_a, reg_b, out_port, pc, c_flag, halted}
  typedef logic [4*W+1:0] obs_t;

  typedef struct {
    string        name;
    logic         en;
    logic         wr;
    logic [1:0]   dst;
    logic         jnc;
    logic [W-1:0] alu;
    logic         carry;
    obs_t         exp;
  } vec_t;

  vec_t vecs[$];
  logic [4*W+1:0] exp_q[$];
  string          name_q[$];
  int             n_vec;
  int             n_miss;

  function automatic obs_t pk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] o, input logic [W-1:0] p,
                              input logic c, input logic h);
    return {a, b, o, p, c, h};
  endfunction

  function automatic void add(input string nm, input logic e, input logic w,
                              input logic [1:0] d, input logic j,
                              input logic [W-1:0] al, input logic cy, input obs_t ex);
    vec_t v;
    v.name = nm; v.en = e; v.wr = w; v.dst = d; v.jnc = j;
    v.alu = al; v.carry = cy; v.exp = ex;
    vecs.push_back(v);
  endfunction

  // scoreboard
  task automatic push_exp(input string nm, input obs_t ex);
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  task automatic pop_cmp();
    obs_t  got;
    obs_t  ex;
    string nm;
    got = {reg_a, reg_b, out_port, pc, c_flag, halted};
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_empty got=%h required=<entry>", got);
      return;
    end
    ex = exp_q.pop_front();
    nm = name_q.pop_front();
    n_vec++;
    if (got !== ex) begin
      n_miss++;
      $display("FAIL %s got a=%h b=%h out=%h pc=%h c=%b h=%b required a=%h b=%h out=%h pc=%h c=%b h=%b",
               nm, got[4*W+1 -: W], got[3*W+1 -: W], got[2*W+1 -: W], got[W+1 -: W], got[1], got[0],
               ex[4*W+1 -: W], ex[3*W+1 -: W], ex[2*W+1 -: W], ex[W+1 -: W], ex[1], ex[0]);
    end
  endtask

  // drivers
  task automatic drive(input logic e, input logic w, input logic [1:0] d,
                       input logic j, input logic [W-1:0] al, input logic cy);
    en = e; wr = w; dst = d; jnc = j; alu_out = al; alu_carry = cy;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v.en, v.wr, v.dst, v.jnc, v.alu, v.carry);
    push_exp(v.name, v.exp);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, 1'b0);

    // counting with wr=0: pc 1..15 then wrap to 0
    for (int i = 0; i < 16; i++) begin
      add("pc_count", 1, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          pk(0, 0, 0, 4'((i + 1) % 16), 0, 0));
    end
    add("write_a",       1, 1, 2'd0, 0, 4'b0110, 1, pk(6, 0, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++) begin
      add("en_low_hold", 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          pk(6, 0, 0, 1, 1, 0));
    end
    add("jnc_suppressed", 1, 1, 2'd3, 1, 4'b1010, 1, pk(6, 0, 0, 2, 1, 0));
    add("jnc_b_skipped",  1, 1, 2'd1, 1, 4'b1111, 0, pk(6, 0, 0, 3, 0, 0));
    add("jnc_jump_taken", 1, 1, 2'd3, 1, 4'b1010, 0, pk(6, 0, 0, 10, 0, 0));
    add("jnc_write_b",    1, 1, 2'd1, 1, 4'b1111, 1, pk(6, 15, 0, 11, 1, 0));
    add("write_out",      1, 1, 2'd2, 0, 4'b1001, 0, pk(6, 15, 9, 12, 0, 0));
    add("jnc_write_out",  1, 1, 2'd2, 1, 4'b0011, 1, pk(6, 15, 3, 13, 1, 0));
    add("jnc_a_skipped",  1, 1, 2'd0, 1, 4'b0000, 0, pk(6, 15, 3, 14, 0, 0));
    add("wr0_keeps_c",    1, 0, 2'd0, 0, 4'b0111, 1, pk(6, 15, 3, 15, 0, 0));
    add("wrap_keeps_c",   1, 0, 2'd0, 0, 4'b0111, 1, pk(6, 15, 3, 0, 0, 0));
    add("jump_to_5",      1, 1, 2'd3, 0, 4'b0101, 0, pk(6, 15, 3, 5, 0, 0));
    add("jump_to_self",   1, 1, 2'd3, 0, 4'b0101, 0, pk(6, 15, 3, 5, 0, HALT_EN));
    add("self_again",     1, 1, 2'd3, 0, 4'b0101, 1,
        HALT_EN ? pk(6, 15, 3, 5, 0, 1) : pk(6, 15, 3, 5, 1, 0));
    add("step_after_self", 1, 0, 2'd0, 0, 4'b0000, 0,
        HALT_EN ? pk(6, 15, 3, 5, 0, 1) : pk(6, 15, 3, 6, 1, 0));

    // reset state while held, then after release with en=0
    repeat (2) @(negedge clk);
    #1;
    push_exp("reset_held", pk(0, 0, 0, 0, 0, 0));
    pop_cmp();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp("reset_release", pk(0, 0, 0, 0, 0, 0));
    pop_cmp();

    foreach (vecs[i]) apply(vecs[i]);

    // asynchronous reset mid-cycle with an update in flight
    do_reset();
    apply('{name: "prep_b_carry", en: 1, wr: 1, dst: 2'd1, jnc: 0, alu: 4'b1111,
            carry: 1, exp: pk(0, 15, 0, 1, 1, 0)});
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 4'b0111, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_clear", pk(0, 0, 0, 0, 0, 0));
    pop_cmp();
    @(posedge clk);
    #1;
    push_exp("inflight_dropped", pk(0, 0, 0, 0, 0, 0));
    pop_cmp();
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    apply('{name: "first_step_pc0", en: 1, wr: 1, dst: 2'd0, jnc: 0, alu: 4'b0100,
            carry: 0, exp: pk(4, 0, 0, 1, 0, 0)});
    apply('{name: "first_jnc_c0", en: 1, wr: 1, dst: 2'd3, jnc: 1, alu: 4'b1001,
            carry: 0, exp: pk(4, 0, 0, 9, 0, 0)});

    // halt is only cleared by reset
    apply('{name: "jump_to_9_self", en: 1, wr: 1, dst: 2'd3, jnc: 0, alu: 4'b1001,
            carry: 1, exp: pk(4, 0, 0, 9, 1, HALT_EN)});
    do_reset();
    @(posedge clk);
    #1;
    push_exp("halt_cleared", pk(0, 0, 0, 0, 0, 0));
    pop_cmp();
    apply('{name: "step_after_clear", en: 1, wr: 0, dst: 2'd0, jnc: 0, alu: 4'b0000,
            carry: 0, exp: pk(0, 0, 0, 1, 0, 0)});

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
